// File: rtl/mac_pkg.sv
// Shared widths and FSM state encoding for the MAC sequencer.
package mac_pkg;

  localparam int unsigned A_W   = 8;
  localparam int unsigned B_W   = 10;
  localparam int unsigned ACC_W = 25;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StRun,
    StDrain,
    StCapture,
    StDone
  } mac_state_e;

endpackage

// File: rtl/mac_seq_addr_gen.sv
// Element index counter and wrapping base+offset operand address generators.
module mac_seq_addr_gen #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  output logic [ADDR_W:0]   idx
);

  localparam logic [ADDR_W:0] IdxOne = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W-1:0] a_base_q;
  logic [ADDR_W-1:0] b_base_q;
  logic [ADDR_W:0]   idx_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      a_base_q <= '0;
      b_base_q <= '0;
      idx_q    <= '0;
    end else if (load) begin
      a_base_q <= a_base;
      b_base_q <= b_base;
      idx_q    <= '0;
    end else if (step) begin
      idx_q <= idx_q + IdxOne;
    end
  end

  // ADDR_W-bit sums wrap modulo 2^ADDR_W.
  assign a_addr = a_base_q + idx_q[ADDR_W-1:0];
  assign b_addr = b_base_q + idx_q[ADDR_W-1:0];
  assign idx    = idx_q;

endmodule

// File: rtl/mac_seq_ctrl.sv
// Job sequencer for a multiply-accumulate datapath with 1-cycle operand memories.
// Define MAC_SEQ_RELU_EN to clamp negative captured results to zero.
module mac_seq_ctrl #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned ACC_W  = mac_pkg::ACC_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   len,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  output logic              rd_en,
  output logic              mac_clr,
  output logic              mac_en,
  input  logic [ACC_W-1:0]  mac_result,
  output logic [ACC_W-1:0]  result,
  output logic              done,
  output logic              busy
);

  import mac_pkg::*;

  localparam logic [ADDR_W:0] LenOne = {{ADDR_W{1'b0}}, 1'b1};

  mac_state_e        state_q, state_d;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   idx;
  logic              accept;
  logic              rd_en_q, mac_en_q, mac_clr_q, done_q;
  logic [ACC_W-1:0]  result_q;
  logic [ACC_W-1:0]  capture_val;

  assign accept = (state_q == StIdle) && start;

  mac_seq_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk    (clk),
    .clr    (clr),
    .load   (accept),
    .step   (state_q == StRun),
    .a_base (a_base),
    .b_base (b_base),
    .a_addr (a_addr),
    .b_addr (b_addr),
    .idx    (idx)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start) state_d = StClear;
      StClear:   state_d = (len_q == '0) ? StCapture : StRun;
      StRun:     if (idx == len_q - LenOne) state_d = StDrain;
      StDrain:   state_d = StCapture;
      StCapture: state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
    if (abort && (state_q != StIdle)) state_d = StIdle;
  end

`ifdef MAC_SEQ_RELU_EN
  assign capture_val = mac_result[ACC_W-1] ? '0 : mac_result;
`else
  assign capture_val = mac_result;
`endif

  // Strobes are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= StIdle;
      len_q     <= '0;
      rd_en_q   <= 1'b0;
      mac_en_q  <= 1'b0;
      mac_clr_q <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      if (accept) len_q <= len;
      mac_clr_q <= (state_d == StClear);
      rd_en_q   <= (state_d == StRun);
      mac_en_q  <= rd_en_q && (state_d != StIdle);
      done_q    <= (state_d == StDone);
      if ((state_q == StCapture) && (state_d == StDone)) result_q <= capture_val;
    end
  end

  assign rd_en   = rd_en_q;
  assign mac_en  = mac_en_q;
  assign mac_clr = mac_clr_q;
  assign done    = done_q;
  assign result  = result_q;
  assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Scoreboard bench for mac_seq_ctrl with behavioural operand memories and MAC.
module tb_mac_seq_ctrl;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned ACC_W  = 25;
  localparam int          DEPTH  = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              clr = 1'b1, start = 1'b0, abort = 1'b0;
  logic [ADDR_W:0]   len = '0;
  logic [ADDR_W-1:0] a_base = '0, b_base = '0;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic              rd_en, mac_clr, mac_en, done, busy;
  logic [ACC_W-1:0]  mac_result, result;

  mac_seq_ctrl #(
    .ADDR_W (ADDR_W),
    .ACC_W  (ACC_W)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .start      (start),
    .abort      (abort),
    .len        (len),
    .a_base     (a_base),
    .b_base     (b_base),
    .a_addr     (a_addr),
    .b_addr     (b_addr),
    .rd_en      (rd_en),
    .mac_clr    (mac_clr),
    .mac_en     (mac_en),
    .mac_result (mac_result),
    .result     (result),
    .done       (done),
    .busy       (busy)
  );

  // Environment: registered operand memories and a MAC accumulator.
  logic signed [7:0]  a_mem [DEPTH];
  logic signed [9:0]  b_mem [DEPTH];
  logic signed [7:0]  a_q = '0;
  logic signed [9:0]  b_q = '0;
  logic signed [17:0] prod;
  logic [ACC_W-1:0]   acc = '0;

  assign prod       = a_q * b_q;
  assign mac_result = acc;

  always @(posedge clk) begin
    if (rd_en) begin
      a_q <= a_mem[a_addr];
      b_q <= b_mem[b_addr];
    end
    if (mac_clr) acc <= '0;
    else if (mac_en) acc <= acc + {{(ACC_W-18){prod[17]}}, prod};
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [ACC_W-1:0] res;
    int               t0;
    int               lat;
  } exp_t;

  exp_t              sb [$];
  logic [ADDR_W-1:0] aq [$];
  logic [ADDR_W-1:0] bq [$];

  // Reference: dot product over wrapped addresses, truncated to ACC_W.
  function automatic logic [ACC_W-1:0] ref_mac(input int ab, input int bb, input int n);
    int s;
    logic [ACC_W-1:0] t;
    s = 0;
    for (int i = 0; i < n; i++) s += int'(a_mem[(ab + i) % DEPTH]) * int'(b_mem[(bb + i) % DEPTH]);
    t = ACC_W'(s);
`ifdef MAC_SEQ_RELU_EN
    if (t[ACC_W-1]) t = '0;
`endif
    return t;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    logic [ADDR_W-1:0] ea, eb;
    if (rd_en) begin
      if (aq.size() == 0) check("rd_en_unexpected", 64'(rd_en), 64'(0));
      else begin
        ea = aq.pop_front();
        eb = bq.pop_front();
        check("a_addr", 64'(a_addr), 64'(ea));
        check("b_addr", 64'(b_addr), 64'(eb));
      end
    end
    if (done) begin
      if (sb.size() == 0) check("done_unexpected", 64'(done), 64'(0));
      else begin
        e = sb.pop_front();
        check("result", 64'(result), 64'(e.res));
        check("done_latency", 64'(cyc - e.t0), 64'(e.lat));
      end
    end
  end

  // Called away from the rising edge; returns at the falling edge of the cycle after start.
  task automatic start_job(input int n, input int ab, input int bb, input bit with_abort,
                           input bit expect_accept);
    exp_t e;
    logic [ADDR_W-1:0] t;
    start  = 1'b1;
    abort  = with_abort;
    len    = (ADDR_W + 1)'(n);
    a_base = ADDR_W'(ab);
    b_base = ADDR_W'(bb);
    if (expect_accept) begin
      e.res = ref_mac(ab, bb, n);
      e.lat = (n == 0) ? 2 : n + 3;
      for (int i = 0; i < n; i++) begin
        t = ADDR_W'((ab + i) % DEPTH);
        aq.push_back(t);
        t = ADDR_W'((bb + i) % DEPTH);
        bq.push_back(t);
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    if (expect_accept) begin
      e.t0 = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    if (expect_accept) begin
      check("mac_clr_pulse", 64'(mac_clr), 64'(1));
      check("busy_after_start", 64'(busy), 64'(1));
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    check("idle_timeout", 64'(busy), 64'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_result"}, 64'(result), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_rd_en"}, 64'(rd_en), 64'(0));
    check({tag, "_mac_en"}, 64'(mac_en), 64'(0));
    check({tag, "_mac_clr"}, 64'(mac_clr), 64'(0));
    check({tag, "_a_addr"}, 64'(a_addr), 64'(0));
    check({tag, "_b_addr"}, 64'(b_addr), 64'(0));
  endtask

  logic [ACC_W-1:0] exp035, prev;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      a_mem[i] = 8'($urandom);
      b_mem[i] = 10'($urandom);
    end
    a_mem[0] = 8'sd3;
    a_mem[1] = 8'sd5;
    b_mem[0] = 10'sd2;
    b_mem[1] = -10'sd4;

    // Reset held with start and abort asserted: clr wins.
    start = 1'b1;
    abort = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    clr   = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("idle_after_reset", 64'(busy), 64'(0));

    // Signed dot product {3,5}.{2,-4}.
    exp035 = 25'h1FFFFF2;
`ifdef MAC_SEQ_RELU_EN
    exp035 = '0;
`endif
    start_job(2, 0, 0, 1'b0, 1'b1);
    wait_idle();
    check("dot2_result", 64'(result), 64'(exp035));

    // Empty job.
    start_job(0, 5, 9, 1'b0, 1'b1);
    wait_idle();
    check("len0_result", 64'(result), 64'(0));

    // Address wrap from 254.
    start_job(4, 254, 100, 1'b0, 1'b1);
    wait_idle();

    // Abort in IDLE is a no-op.
    prev = result;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    check("idle_abort_busy", 64'(busy), 64'(0));
    check("idle_abort_result", 64'(result), 64'(prev));

    // Abort in the second RUN cycle, then restart at once.
    start_job(8, 10, 20, 1'b0, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    void'(sb.pop_back());
    aq.delete();
    bq.delete();
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_rd_en", 64'(rd_en), 64'(0));
    check("abort_mac_en", 64'(mac_en), 64'(0));
    check("abort_mac_clr", 64'(mac_clr), 64'(0));
    check("abort_result", 64'(result), 64'(prev));
    start_job(5, 30, 40, 1'b0, 1'b1);
    wait_idle();

    // Start while busy is dropped; only one done expected.
    start_job(6, 50, 60, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    start = 1'b1;
    len   = 9'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    // clr during DRAIN.
    start_job(3, 70, 80, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    clr = 1'b1;
    @(negedge clk);
    check("drain_mac_en", 64'(mac_en), 64'(1));
    check("drain_rd_en", 64'(rd_en), 64'(0));
    @(posedge clk);
    #1;
    clr = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    check_all_zero("clr_drain");

    // Randomised jobs, some with abort alongside start in IDLE.
    for (int j = 0; j < 25; j++) begin
      start_job(int'($urandom_range(0, 24)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0), 1'b1);
      wait_idle();
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'(0));
    check("addr_queue_drained", 64'(aq.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
